sensor_conditioner: RTL
=======================

Name: sensor_conditioner

Overview:
- Sits directly upstream of the 5-lane traffic light controller and drives its five sensor inputs (e_left, e_str, w_left, w_str, ns).
- Synchronises raw asynchronous loop-detector inputs and debounces them with separate on and off qualification counts.
- Latches a per-lane "call" so that a vehicle which crosses a detector while its light is not green still holds the request until that lane is served.
- Consumes the controller's five light outputs as feedback to clear the calls.

Parameters:
- SYNC_STAGES, 2: synchroniser flops per raw input. Legal values are 2 or more.
- ON_CYCLES, 3: consecutive synchronised-high samples needed to declare presence. Legal values are 1 or more.
- OFF_CYCLES, 4: consecutive synchronised-low samples needed to declare absence. Legal values are 1 or more.

Ports:
- clk  in  1  system clock; all flops on the rising edge.
- reset  in  1  asynchronous, active-low. reset=0 clears all state immediately; release is synchronous to clk.
- raw_e_left, raw_e_str, raw_w_left, raw_w_str, raw_ns  in  1 each  raw detector levels, asynchronous to clk.
- e_left_light, e_str_light, w_left_light, w_str_light, ns_light  in  colors each  light feedback from the controller.
- e_left_sensor, e_str_sensor, w_left_sensor, w_str_sensor, ns_sensor  out  1 each  conditioned request to the controller; registered.

Behaviour:
- Five identical, independent lane channels. Each channel has:
  - a synchroniser chain;
  - a debounce FSM with a saturating counter of width $clog2(max(ON_CYCLES,OFF_CYCLES)+1);
  - a det flop and a call flop.
- Each output is the OR of its lane's det and call, registered so there is no combinational path from input to output.
- Reset (reset=0, at any time including mid-count):
  - synchroniser flops, counter, det and call all go to 0; FSM goes to ABSENT;
  - all sensor outputs are 0 while reset is held and on the first cycle after release.
- Synchroniser: s is the last stage of the chain. A raw change is first visible to the FSM at rising edge k+SYNC_STAGES, where k is the first edge that samples the change.
- FSM states and transitions (evaluated on s each edge):
  - ABSENT (det=0): s=1 → ARMING with cnt=1, or straight to PRESENT if ON_CYCLES=1. s=0 → stay, cnt=0.
  - ARMING (det=0): s=1 → cnt+1; when cnt+1==ON_CYCLES → PRESENT with det=1, cnt=0. s=0 → ABSENT, cnt=0 (glitch rejected).
  - PRESENT (det=1): s=0 → CLEARING with cnt=1, or straight to ABSENT if OFF_CYCLES=1. s=1 → stay, cnt=0.
  - CLEARING (det=1): s=0 → cnt+1; when cnt+1==OFF_CYCLES → ABSENT with det=0, cnt=0. s=1 → PRESENT, cnt=0 (dropout rejected).
  - det changes on the same edge as the qualifying transition.
- Latency with default parameters:
  - rise: raw high sampled at edge 0 → sensor=1 after edge 4 (2 sync + 3 on).
  - fall: raw low sampled at edge k → sensor drops after edge k+5, provided call=0.
- Call latch, per lane, evaluated at the edge where det goes 0→1:
  - if the lane light is not green, call is set;
  - if the lane light is green, call is not set.
- Call clear: any edge where the lane light==green clears call. Clear has priority over set on the same edge.
- Call is held while the light is yellow or red. A car arriving on yellow is therefore queued for the next green.
- There are no cross-lane interactions; simultaneous activity on all lanes is handled independently.
- Counters saturate and never wrap. Out-of-range colors values are treated as not-green.

Decomposition:
- The colors enum (red, yellow, green) is already in light_package. Import it; do not redefine it.
- Add to light_package:
  - lane index typedef, enum {LN_E_LEFT, LN_E_STR, LN_W_LEFT, LN_W_STR, LN_NS};
  - debounce state typedef, enum {DB_ABSENT, DB_ARMING, DB_PRESENT, DB_CLEARING}.
- One sub-module, sensor_lane: synchroniser, FSM, counter, det and call for a single lane, with the same parameters.
- The top level instantiates sensor_lane five times and contains no other logic.

Test Plan:
- Reset: hold reset=0 for 3 cycles with all raw=1 → all sensors 0. Release → first sensor rise after 5 edges. Assert reset=0 mid-ARMING → outputs stay 0 and the count restarts from 0 after release.
- Debounce rise: raw_ns 0→1 held, ns_light=red → ns_sensor=1 exactly after edge 4. Raw pulse 2 cycles wide → ns_sensor never rises.
- Debounce fall: ns_light=green throughout (call=0). raw_ns goes 1→0 at edge 10 → ns_sensor=0 after edge 15. A 3-cycle low dropout (raw low at edges 20-22, high again at 23) → ns_sensor stays 1.
- Call latch: raw_e_left high at edges 0-5 then low, e_left_light=red → sensor stays 1 past the debounce fall. Set e_left_light=green at edge 30 → e_left_sensor=0 after edge 30. Sensor stays 0 after the light returns to red.
- Simultaneous events: det rises on an edge where w_str_light=green → call stays 0, and the sensor falls 5 edges after raw drops. det rises during yellow → call set and held through red.
- Independence: all five raws driven with different staggered patterns → each output matches a per-lane reference model every cycle.

Source files
------------

// File: rtl/light_package.sv
// Shared types for the traffic light controller and its sensor front end.
package light_package;

    // Light colours driven by the controller; encodings 2'b11 is unused.
    typedef enum logic [1:0] {
        red,
        yellow,
        green
    } colors;

    // Lane index, in the order lanes are wired through the design.
    typedef enum logic [2:0] {
        LN_E_LEFT,
        LN_E_STR,
        LN_W_LEFT,
        LN_W_STR,
        LN_NS
    } lane_t;

    // Debounce FSM states; det is high in PRESENT and CLEARING.
    typedef enum logic [1:0] {
        DB_ABSENT,
        DB_ARMING,
        DB_PRESENT,
        DB_CLEARING
    } db_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sensor_lane.sv
// One lane of detector conditioning: synchroniser, on/off debounce,
// vehicle call latch and a registered request output.
module sensor_lane
    import light_package::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int ON_CYCLES   = 3,
    parameter int OFF_CYCLES  = 4
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  raw,
    input  colors light,
    output logic  sensor
);

    localparam int CNT_W = $clog2(max_int(ON_CYCLES, OFF_CYCLES) + 1);

    // Counter value at which the next qualifying sample completes the run.
    localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    db_state_t              state, state_next;
    logic [CNT_W-1:0]       cnt, cnt_next;
    logic                   det, det_next;
    logic                   call, call_next;
    logic                   is_green;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    assign s        = sync_q[SYNC_STAGES-1];
    assign is_green = (light == green);

    // Synchroniser chain: raw enters bit 0, s leaves the top bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        end
    end

    // Debounce next-state, counter, det and call decisions.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        det_next   = det;
        call_next  = call;
        case (state)
            DB_ABSENT: begin
                det_next = 1'b0;
                cnt_next = '0;
                if (s) begin
                    if (ON_CYCLES == 1) begin
                        state_next = DB_PRESENT;
                        det_next   = 1'b1;
                    end else begin
                        state_next = DB_ARMING;
                        cnt_next   = CNT_W'(1);
                    end
                end
            end
            DB_ARMING: begin
                if (!s) begin
                    state_next = DB_ABSENT;
                    cnt_next   = '0;
                end else if (cnt >= ON_LAST) begin
                    state_next = DB_PRESENT;
                    det_next   = 1'b1;
                    cnt_next   = '0;
                end else begin
                    cnt_next = sat_inc(cnt);
                end
            end
            DB_PRESENT: begin
                det_next = 1'b1;
                cnt_next = '0;
                if (!s) begin
                    if (OFF_CYCLES == 1) begin
                        state_next = DB_ABSENT;
                        det_next   = 1'b0;
                    end else begin
                        state_next = DB_CLEARING;
                        cnt_next   = CNT_W'(1);
                    end
                end
            end
            DB_CLEARING: begin
                if (s) begin
                    state_next = DB_PRESENT;
                    cnt_next   = '0;
                end else if (cnt >= OFF_LAST) begin
                    state_next = DB_ABSENT;
                    det_next   = 1'b0;
                    cnt_next   = '0;
                end else begin
                    cnt_next = sat_inc(cnt);
                end
            end
            default: begin
                state_next = DB_ABSENT;
                det_next   = 1'b0;
                cnt_next   = '0;
            end
        endcase

        // Green always clears; otherwise a fresh detection raises the call.
        if (is_green) begin
            call_next = 1'b0;
        end else if (det_next && !det) begin
            call_next = 1'b1;
        end
    end

    // State registers; sensor is built from next values so the output is
    // registered yet changes on the same edge as det.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= DB_ABSENT;
            cnt    <= '0;
            det    <= 1'b0;
            call   <= 1'b0;
            sensor <= 1'b0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            det    <= det_next;
            call   <= call_next;
            sensor <= det_next | call_next;
        end
    end

endmodule

// File: rtl/sensor_conditioner.sv
// Conditions the five raw loop detectors feeding the traffic light
// controller; each lane is an independent sensor_lane.
module sensor_conditioner
    import light_package::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int ON_CYCLES   = 3,
    parameter int OFF_CYCLES  = 4
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  raw_e_left,
    input  logic  raw_e_str,
    input  logic  raw_w_left,
    input  logic  raw_w_str,
    input  logic  raw_ns,
    input  colors e_left_light,
    input  colors e_str_light,
    input  colors w_left_light,
    input  colors w_str_light,
    input  colors ns_light,
    output logic  e_left_sensor,
    output logic  e_str_sensor,
    output logic  w_left_sensor,
    output logic  w_str_sensor,
    output logic  ns_sensor
);

    sensor_lane #(
        .SYNC_STAGES(SYNC_STAGES), .ON_CYCLES(ON_CYCLES), .OFF_CYCLES(OFF_CYCLES)
    ) u_e_left (
        .clk(clk), .reset(reset), .raw(raw_e_left), .light(e_left_light), .sensor(e_left_sensor)
    );

    sensor_lane #(
        .SYNC_STAGES(SYNC_STAGES), .ON_CYCLES(ON_CYCLES), .OFF_CYCLES(OFF_CYCLES)
    ) u_e_str (
        .clk(clk), .reset(reset), .raw(raw_e_str), .light(e_str_light), .sensor(e_str_sensor)
    );

    sensor_lane #(
        .SYNC_STAGES(SYNC_STAGES), .ON_CYCLES(ON_CYCLES), .OFF_CYCLES(OFF_CYCLES)
    ) u_w_left (
        .clk(clk), .reset(reset), .raw(raw_w_left), .light(w_left_light), .sensor(w_left_sensor)
    );

    sensor_lane #(
        .SYNC_STAGES(SYNC_STAGES), .ON_CYCLES(ON_CYCLES), .OFF_CYCLES(OFF_CYCLES)
    ) u_w_str (
        .clk(clk), .reset(reset), .raw(raw_w_str), .light(w_str_light), .sensor(w_str_sensor)
    );

    sensor_lane #(
        .SYNC_STAGES(SYNC_STAGES), .ON_CYCLES(ON_CYCLES), .OFF_CYCLES(OFF_CYCLES)
    ) u_ns (
        .clk(clk), .reset(reset), .raw(raw_ns), .light(ns_light), .sensor(ns_sensor)
    );

endmodule
